burst_mem_responder: RTL

- Synthesizable responder for the CPU top-level burst memory port (pmem_address/pmem_read/pmem_write/pmem_wdata/pmem_rdata/mem_resp).
- Serves each line request as fixed-length beat bursts after a programmable latency, backed by internal line storage.
- Used as the on-chip memory endpoint in integration builds and standalone CPU benches; replaces the behavioural memory model.

---
 rtl/burst_mem_pkg.sv | 23 ++
 rtl/burst_mem_if.sv | 25 ++
 rtl/burst_mem_array.sv | 37 +++
 rtl/burst_mem_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
package burst_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, RECOVER} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;

  // Byte offset within a 256-bit line (4 beats x 64 bits).
  localparam int OFFSET_BITS = 5;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_BEAT_W = 64;
  localparam int DEF_BEATS  = 4;
  localparam int DEF_LINES  = 256;

  // Width of an index into n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [DEF_BEAT_W-1:0] beat_t;
  typedef logic [DEF_ADDR_W-1:0] line_addr_t;

endpackage

// File: rtl/burst_mem_if.sv
// CPU burst memory port: request side driven by the initiator, beat
// strobe and read data driven by the responder.
interface burst_mem_if #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64
) ();

  logic [ADDR_W-1:0] pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata;
  logic              mem_resp;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, mem_resp
  );

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, mem_resp
  );

endinterface

// File: rtl/burst_mem_array.sv
// Line storage addressed by {line index, beat}. One write port and one
// registered read port; the read register returns zero when not enabled
// so it can drive the bus read data directly. Contents are never reset.
module burst_mem_array #(
  parameter int BEAT_W = 64,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [BEAT_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [BEAT_W-1:0] wr_data_i
);

  localparam int DEPTH = 1 << AW;

  logic [BEAT_W-1:0] mem_q [DEPTH];
  logic [BEAT_W-1:0] rd_data_q;

  // Write port: one beat per enabled edge.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read port, zero whenever no read beat is being presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    else              rd_data_q <= '0;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/burst_mem_responder.sv
// On-chip responder for the CPU burst memory port. Each accepted line
// request is answered with BEATS consecutive mem_resp beats, the first one
// in the LATENCY-th cycle after the accepting edge.
// Optional protocol checker: define BURST_MEM_PROTO_CHK_EN to drive a
// sticky err flag; otherwise err is tied low.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no request in flight; accepts read/write, latches idx + op
// WAIT    | counting down the access latency
// BURST   | mem_resp high, one beat per cycle (read out or write in)
// RECOVER | one dead cycle after the last beat; requests ignored
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BEAT_W  = DEF_BEAT_W,
  parameter int BEATS   = DEF_BEATS,
  parameter int LINES   = DEF_LINES,
  parameter int LATENCY = 10
) (
  input  logic           clk,
  input  logic           rst,
  burst_mem_if.slave     bus,
  output logic           err
);

  localparam int IDX_W  = idx_width(LINES);
  localparam int BEAT_CW = idx_width(BEATS);
  localparam int LAT_W  = $clog2(LATENCY) + 1;
  localparam int MEM_AW = IDX_W + BEAT_CW;

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BEAT_CW-1:0]   beat_q, beat_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 mem_resp_q;

  logic [ADDR_W-1:0]    addr_in;
  logic [IDX_W-1:0]     idx_in;
  logic                 req;
  logic                 unused_addr;

  logic                 rd_en;
  logic [MEM_AW-1:0]    rd_addr;
  logic [BEAT_W-1:0]    rd_data;
  logic                 wr_en;
  logic [MEM_AW-1:0]    wr_addr;

  assign addr_in     = bus.pmem_address;
  assign idx_in      = addr_in[OFFSET_BITS +: IDX_W];
  // Offset and upper address bits alias onto the same line.
  assign unused_addr = ^addr_in;
  assign req         = bus.pmem_read | bus.pmem_write;

  // Next-state logic: acceptance, latency countdown, beat sequencing, abort.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          // Read wins when both strobes are high.
          op_d    = bus.pmem_read ? OP_READ : OP_WRITE;
          idx_d   = idx_in;
          beat_d  = '0;
          lat_d   = LAT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
          if (lat_d == '0) begin
            state_d = BURST;
            beat_d  = '0;
          end
        end
      end
      BURST: begin
        if (!req) begin
          state_d = IDLE;
        end else if (beat_q == BEAT_CW'(BEATS - 1)) begin
          state_d = RECOVER;
        end else begin
          beat_d = beat_q + BEAT_CW'(1);
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and counters; mem_resp registered from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      idx_q      <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
      mem_resp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      mem_resp_q <= (state_d == BURST);
    end
  end

  // Read is issued one cycle ahead so the registered data lines up with mem_resp.
  assign rd_en   = (state_d == BURST) && (op_d == OP_READ);
  assign rd_addr = {idx_d, beat_d};
  // A write beat lands only if the initiator is still holding the request.
  assign wr_en   = (state_q == BURST) && (op_q == OP_WRITE) && req;
  assign wr_addr = {idx_q, beat_q};

  burst_mem_array #(
    .BEAT_W (BEAT_W),
    .AW     (MEM_AW)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (bus.pmem_wdata)
  );

  assign bus.mem_resp   = mem_resp_q;
  assign bus.pmem_rdata = rd_data;

`ifdef BURST_MEM_PROTO_CHK_EN
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        strb_q;
  logic              rec_hi_q;
  logic              err_q;
  logic              err_set;

  // Detect protocol violations against the request latched at acceptance.
  always_comb begin
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && bus.pmem_read && bus.pmem_write) err_set = 1'b1;
        if (req && rec_hi_q)                        err_set = 1'b1;
      end
      WAIT, BURST: begin
        if (!req)                                            err_set = 1'b1;
        else if (addr_in != addr_q)                          err_set = 1'b1;
        else if ({bus.pmem_read, bus.pmem_write} != strb_q)  err_set = 1'b1;
      end
      default: err_set = 1'b0;
    endcase
  end

  // Checker state: full request snapshot, request-held-through-RECOVER flag, sticky err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      strb_q   <= '0;
      rec_hi_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && req) begin
        addr_q <= addr_in;
        strb_q <= {bus.pmem_read, bus.pmem_write};
      end
      rec_hi_q <= (state_q == RECOVER) && req;
      err_q    <= err_q | err_set;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
